// File: rtl/down_counter_timer_if.sv
// Control/status bundle between a controller (master) and down_counter_timer (slave).
interface down_counter_timer_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic             stop;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             zero;

  modport master (
    output load, load_val, start, pause, stop,
    input  count, busy, done, zero
  );

  modport slave (
    input  load, load_val, start, pause, stop,
    output count, busy, done, zero
  );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable prescaled down counter with start/done handshake.
// Define DOWN_COUNTER_AUTORELOAD_EN for periodic reload-on-expiry instead of one-shot.
module down_counter_timer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input logic                clk,
  input logic                rst,
  down_counter_timer_if.slave bus
);

  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] reload;
  logic [PS_W-1:0]  presc;
  logic             done;
  logic [WIDTH-1:0] eff_count;
  logic             tick;
  logic             last_step;

  function automatic logic [WIDTH-1:0] dec_sat(input logic [WIDTH-1:0] v);
    return (v == '0) ? '0 : v - WIDTH'(1);
  endfunction

  // A same-cycle load decides whether start has anything to count.
  always_comb begin
    eff_count = bus.load ? bus.load_val : count;
    tick      = (presc == PS_LAST);
    last_step = (count <= WIDTH'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      count  <= '0;
      reload <= '0;
      presc  <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.load) begin
            count  <= bus.load_val;
            reload <= bus.load_val;
          end
          if (bus.start) begin
            if (eff_count != '0) begin
              state <= ST_RUN;
              presc <= '0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (bus.stop) begin
            state <= ST_IDLE;
          end else if (!bus.pause) begin
            if (tick) begin
              presc <= '0;
              if (last_step) begin
                done <= 1'b1;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
                // An empty reload register would spin at zero, so fall back to IDLE.
                count <= reload;
                if (reload == '0) state <= ST_IDLE;
`else
                count <= '0;
                state <= ST_IDLE;
`endif
              end else begin
                count <= dec_sat(count);
              end
            end else begin
              presc <= presc + PS_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.count = count;
  assign bus.busy  = (state == ST_RUN);
  assign bus.done  = done;
  assign bus.zero  = (count == '0);

endmodule

// File: doc/down_counter_timer.md
# down_counter_timer

Loadable, prescaled down counter with a start/done handshake. It is the count-down companion to the team's free-running up counter. A value is loaded, the count runs toward zero at a programmable tick rate, and a one-cycle `done` pulse marks expiry. It serves as the delay/timeout element for the homework datapaths, where a controller loads a cycle budget and waits for `done`.

## Interface
- `WIDTH`, default 4: counter width in bits.
- `PRESCALE`, default 1: clock cycles per decrement. Legal values are ≥1; 1 means decrement every cycle.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `load`  in  1: loads `load_val` into the count and reload registers. Honoured in IDLE only.
- `load_val`  in  WIDTH: value to load.
- `start`  in  1: begins counting. Honoured in IDLE only.
- `pause`  in  1: level input; while high in RUN, the prescaler and count are frozen.
- `stop`  in  1: aborts RUN and returns to IDLE with the count held.
- `count`  out  WIDTH: current count, registered.
- `busy`  out  1: high while in RUN.
- `done`  out  1: registered one-cycle pulse on expiry.
- `zero`  out  1: combinational, `count == 0`.

## Operation
- States:
  - IDLE: waiting for `load` / `start`.
  - RUN: counting down.
- Reset values: state IDLE, `count`=0, reload register=0, prescaler=0, `busy`=0, `done`=0, `zero`=1.
- IDLE behaviour:
  - `load`=1 sets `count`←`load_val` and reload←`load_val`.
  - `start`=1 with an effective count ≠0 moves to RUN and sets prescaler←0. The effective count is `load_val` if `load` is asserted in the same cycle, otherwise `count`.
  - `start`=1 with an effective count of 0 stays in IDLE and pulses `done` on the next cycle.
- RUN behaviour, in priority order:
  1. `rst`
  2. `stop`: go to IDLE. Count and prescaler are held, no `done` pulse.
  3. `pause`: hold everything.
  4. Tick: prescaler increments. When it reaches PRESCALE−1, it is set to 0 and a decrement occurs.
- Decrement from `count` > 1: `count`←`count`−1.
- Terminal decrement from `count`=1: `count`←0, `done`←1 for one cycle, state←IDLE.
- No underflow: the count never wraps below 0. `load` and `start` are ignored in RUN.
- Arithmetic is unsigned, WIDTH bits. The maximum load is 2^WIDTH−1.

## Timing
- `start` sampled at edge k (count N ≠0): `busy`=1 after edge k.
- First decrement at edge k+PRESCALE. Then one decrement every PRESCALE unpaused cycles.
- Count reaches 0 at edge k+N·PRESCALE. At that same edge `done`=1 and `busy`=0. `done` returns to 0 one edge later.
- Each paused cycle extends expiry by exactly one cycle.
- `start` may be reasserted in the cycle `done` is high (IDLE). With a fresh `load` the count restarts with zero idle gap.
- `rst` asserted mid-RUN: all registers take reset values at that edge, and no `done` is produced.

## Configuration
- Macro `DOWN_COUNTER_AUTORELOAD_EN`.
- Defined: the terminal decrement sets `count`←reload and pulses `done`, and the block stays in RUN. This gives a periodic `done` every N·PRESCALE cycles until `stop` or `rst`. `zero` never asserts during RUN.
- Undefined: one-shot behaviour as described in Operation.

## Test plan
- Reset: `rst` high for 2 cycles → `count`=0, `busy`=0, `done`=0, `zero`=1.
- One-shot (WIDTH=4, PRESCALE=1): `load_val`=5 with `load`+`start` in the same cycle → `count` 5,4,3,2,1,0 over 5 cycles. `done` high for exactly the cycle after `count` hits 0; `busy` falls at the same edge.
- Prescale=3 with pause: load 2, start, hold `pause` high for 4 cycles mid-run → `done` arrives 6+4=10 cycles after start.
- Stop and max load: load 15, start, `stop` after 4 decrements → IDLE with `count`=11 and no `done`. A subsequent `start` resumes from 11 and expires 11 cycles later.
- Zero start: with `count`=0, `start` alone → `done` pulses one cycle later, `busy` stays 0. Separately, a mid-run `rst` gives `count`=0 with no `done`.
- Autoreload (macro defined, PRESCALE=1, load 3): → `done` pulses every 3 cycles and `count` cycles 3,2,1,3,2,1… until `stop`.
